// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    // Decode inputs from the instruction register and ALU
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    // Datapath enables and selects
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic [3:0] state;

    modport master (
        input  opcode, funct3, funct7b5, zero,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control, state
    );

    modport slave (
        output opcode, funct3, funct7b5, zero,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, imm_src, alu_control, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: Moore sequencer plus ALU and immediate
// decoders. Outputs are combinational from the state register; pc_write
// additionally depends on zero during BEQ.
module multicycle_controller (
    input  logic                          clock,
    input  logic                          reset,
    multicycle_controller_if.master       bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    state_t     state_q, state_d;

    logic       pc_update;
    logic       branch;
    logic       adr_sel;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] res_sel;
    logic [1:0] src_a_sel;
    logic [1:0] src_b_sel;
    aluop_t     aluop;
    alu_t       alu_ctl;
    logic [1:0] imm_sel;

    // Next-state selection; unused codes fall back to FETCH
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_BEQ:      state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // State register with synchronous reset to FETCH
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state datapath controls (Moore)
    always_comb begin
        pc_update = 1'b0;
        branch    = 1'b0;
        adr_sel   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        reg_we    = 1'b0;
        res_sel   = '0;
        src_a_sel = '0;
        src_b_sel = '0;
        aluop     = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_we     = 1'b1;
                src_b_sel = 2'b10;
                res_sel   = 2'b10;
                pc_update = 1'b1;
            end
            S_DECODE: begin
                src_a_sel = 2'b01;
                src_b_sel = 2'b01;
            end
            S_MEMADR: begin
                src_a_sel = 2'b10;
                src_b_sel = 2'b01;
            end
            S_MEMREAD: begin
                adr_sel = 1'b1;
            end
            S_MEMWB: begin
                res_sel = 2'b01;
                reg_we  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_sel = 1'b1;
                mem_we  = 1'b1;
            end
            S_EXECR: begin
                src_a_sel = 2'b10;
                aluop     = ALUOP_FUNCT;
            end
            S_EXECI: begin
                src_a_sel = 2'b10;
                src_b_sel = 2'b01;
                aluop     = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_we = 1'b1;
            end
            S_JAL: begin
                src_a_sel = 2'b01;
                src_b_sel = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                src_a_sel = 2'b10;
                aluop     = ALUOP_SUB;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU operation decode; only R-type may subtract on funct3 000
    always_comb begin
        alu_ctl = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alu_ctl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (bus.funct3)
                    3'b000:  alu_ctl = (bus.opcode[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctl = ALU_SLT;
                    3'b110:  alu_ctl = ALU_OR;
                    3'b111:  alu_ctl = ALU_AND;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            default: alu_ctl = ALU_ADD;
        endcase
    end

    // Immediate format from opcode alone
    always_comb begin
        imm_sel = 2'b00;
        case (bus.opcode)
            OP_SW:   imm_sel = 2'b01;
            OP_BEQ:  imm_sel = 2'b10;
            OP_JAL:  imm_sel = 2'b11;
            default: imm_sel = 2'b00;
        endcase
    end

    // Reset masks every enable and select so nothing is written while it is held
    assign bus.pc_write    = ~reset & (pc_update | (branch & bus.zero));
    assign bus.adr_src     = ~reset & adr_sel;
    assign bus.mem_write   = ~reset & mem_we;
    assign bus.ir_write    = ~reset & ir_we;
    assign bus.reg_write   = ~reset & reg_we;
    assign bus.result_src  = reset ? 2'b00 : res_sel;
    assign bus.alu_src_a   = reset ? 2'b00 : src_a_sel;
    assign bus.alu_src_b   = reset ? 2'b00 : src_b_sel;
    assign bus.imm_src     = reset ? 2'b00 : imm_sel;
    assign bus.alu_control = reset ? 3'b000 : alu_ctl;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed per-cycle vector table,
// hand-written reset-abort sequences, and a randomized run against an
// instruction-level reference model.
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;

    logic clock = 1'b0;
    logic reset = 1'b1;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // {state, pc_write, ir_write, reg_write, mem_write, adr_src,
    //  result_src, alu_control, imm_src, alu_src_a, alu_src_b}
    typedef struct {
        logic        rst;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        logic [19:0] exp;
    } vec_t;

    vec_t vecs[$];

    typedef struct {
        logic       pcu;
        logic       br;
        logic       adr;
        logic       mw;
        logic       irw;
        logic       rgw;
        logic [1:0] rs;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] aluop;
    } ctl_t;

    ctl_t ctl[16];

    int n_vec  = 0;
    int n_miss = 0;

    function automatic logic [19:0] dut_out();
        return {bus.state, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write,
                bus.adr_src, bus.result_src, bus.alu_control, bus.imm_src,
                bus.alu_src_a, bus.alu_src_b};
    endfunction

    task automatic row(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                       input logic f7, input logic z, input logic [3:0] st,
                       input logic pcw, input logic irw, input logic rgw, input logic mw,
                       input logic adr, input logic [1:0] rs, input logic [2:0] alu,
                       input logic [1:0] imm, input logic [1:0] sa, input logic [1:0] sb);
        vec_t v;
        v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z;
        v.exp = {st, pcw, irw, rgw, mw, adr, rs, alu, imm, sa, sb};
        vecs.push_back(v);
    endtask

    task automatic f_row(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic [1:0] imm);
        row(1'b0, op, f3, f7, z, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 3'b000, imm, 2'b00, 2'b10);
    endtask

    task automatic d_row(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input logic [1:0] imm);
        row(1'b0, op, f3, f7, z, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, imm, 2'b01, 2'b01);
    endtask

    task automatic rst_row(input logic [6:0] op, input logic [3:0] st);
        row(1'b1, op, 3'b000, 1'b1, 1'b1, st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00);
    endtask

    task automatic check(input logic [19:0] exp, input string name);
        logic [19:0] act;
        act = dut_out();
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: actual state=%0d outs=%h, required state=%0d outs=%h",
                     name, act[19:16], act[15:0], exp[19:16], exp[15:0]);
        end
    endtask

    task automatic apply_vecs(input string name);
        foreach (vecs[i]) begin
            reset        = vecs[i].rst;
            bus.opcode   = vecs[i].op;
            bus.funct3   = vecs[i].f3;
            bus.funct7b5 = vecs[i].f7;
            bus.zero     = vecs[i].z;
            #4;
            check(vecs[i].exp, $sformatf("%s[%0d]", name, i));
            @(posedge clock);
            #1;
        end
        vecs.delete();
    endtask

    task automatic setc(input int idx, input logic pcu, input logic br, input logic adr,
                        input logic mw, input logic irw, input logic rgw, input logic [1:0] rs,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] aluop);
        ctl[idx].pcu = pcu; ctl[idx].br = br; ctl[idx].adr = adr; ctl[idx].mw = mw;
        ctl[idx].irw = irw; ctl[idx].rgw = rgw; ctl[idx].rs = rs; ctl[idx].sa = sa;
        ctl[idx].sb = sb; ctl[idx].aluop = aluop;
    endtask

    // ALU operation an instruction needs, from RISC-V semantics
    function automatic logic [2:0] ref_alu(input logic [1:0] aluop, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7);
        if (aluop == 2'b01) return 3'b001;
        if (aluop != 2'b10) return 3'b000;
        case (f3)
            3'b000:  return (op == RT && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] op);
        if (op == SW)  return 2'b01;
        if (op == BEQ) return 2'b10;
        if (op == JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [19:0] ref_out(input logic rst, input int st, input logic [6:0] op,
                                            input logic [2:0] f3, input logic f7, input logic z);
        ctl_t c;
        logic [3:0] s4;
        s4 = 4'(st);
        if (rst) return {s4, 16'h0000};
        c = ctl[st];
        return {s4, c.pcu | (c.br & z), c.irw, c.rgw, c.mw, c.adr, c.rs,
                ref_alu(c.aluop, op, f3, f7), ref_imm(op), c.sa, c.sb};
    endfunction

    int seq[$];

    task automatic build_seq(input logic [6:0] op);
        case (op)
            LW:      seq = '{0, 1, 2, 3, 4};
            SW:      seq = '{0, 1, 2, 5};
            RT:      seq = '{0, 1, 6, 7};
            IT:      seq = '{0, 1, 8, 7};
            BEQ:     seq = '{0, 1, 10};
            JAL:     seq = '{0, 1, 9, 7};
            default: seq = '{0, 1};
        endcase
    endtask

    initial begin
        int m_idx;
        int m_state;
        logic [6:0] pool [6];

        bus.opcode = LW; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Directed table: one row per cycle
        rst_row(SW, 4'd0);
        rst_row(SW, 4'd0);
        // lw: 0,1,2,3,4 (zero toggled in MEMADR has no effect)
        f_row(LW, 3'b010, 1'b0, 1'b0, 2'b00);
        d_row(LW, 3'b010, 1'b0, 1'b0, 2'b00);
        row(0, LW, 3'b010, 0, 1, 4'd2, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b10, 2'b01);
        row(0, LW, 3'b010, 0, 0, 4'd3, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00);
        row(0, LW, 3'b010, 0, 0, 4'd4, 0, 0, 1, 0, 0, 2'b01, 3'b000, 2'b00, 2'b00, 2'b00);
        // sw: 0,1,2,5
        f_row(SW, 3'b010, 1'b0, 1'b0, 2'b01);
        d_row(SW, 3'b010, 1'b0, 1'b0, 2'b01);
        row(0, SW, 3'b010, 0, 0, 4'd2, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b01);
        row(0, SW, 3'b010, 0, 0, 4'd5, 0, 0, 0, 1, 1, 2'b00, 3'b000, 2'b01, 2'b00, 2'b00);
        // R sub
        f_row(RT, 3'b000, 1'b1, 1'b0, 2'b00);
        d_row(RT, 3'b000, 1'b1, 1'b0, 2'b00);
        row(0, RT, 3'b000, 1, 1, 4'd6, 0, 0, 0, 0, 0, 2'b00, 3'b001, 2'b00, 2'b10, 2'b00);
        row(0, RT, 3'b000, 1, 0, 4'd7, 0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00);
        // R add
        f_row(RT, 3'b000, 1'b0, 1'b0, 2'b00);
        d_row(RT, 3'b000, 1'b0, 1'b0, 2'b00);
        row(0, RT, 3'b000, 0, 0, 4'd6, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b10, 2'b00);
        row(0, RT, 3'b000, 0, 0, 4'd7, 0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00);
        // addi with funct7b5 set still adds
        f_row(IT, 3'b000, 1'b1, 1'b0, 2'b00);
        d_row(IT, 3'b000, 1'b1, 1'b0, 2'b00);
        row(0, IT, 3'b000, 1, 0, 4'd8, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b10, 2'b01);
        row(0, IT, 3'b000, 1, 0, 4'd7, 0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00);
        // R and
        f_row(RT, 3'b111, 1'b0, 1'b0, 2'b00);
        d_row(RT, 3'b111, 1'b0, 1'b0, 2'b00);
        row(0, RT, 3'b111, 0, 0, 4'd6, 0, 0, 0, 0, 0, 2'b00, 3'b010, 2'b00, 2'b10, 2'b00);
        row(0, RT, 3'b111, 0, 0, 4'd7, 0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00);
        // ori, slti
        f_row(IT, 3'b110, 1'b0, 1'b0, 2'b00);
        d_row(IT, 3'b110, 1'b0, 1'b0, 2'b00);
        row(0, IT, 3'b110, 0, 0, 4'd8, 0, 0, 0, 0, 0, 2'b00, 3'b011, 2'b00, 2'b10, 2'b01);
        row(0, IT, 3'b110, 0, 0, 4'd7, 0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00);
        f_row(IT, 3'b010, 1'b0, 1'b0, 2'b00);
        d_row(IT, 3'b010, 1'b0, 1'b0, 2'b00);
        row(0, IT, 3'b010, 0, 0, 4'd8, 0, 0, 0, 0, 0, 2'b00, 3'b101, 2'b00, 2'b10, 2'b01);
        row(0, IT, 3'b010, 0, 0, 4'd7, 0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00);
        // beq taken (zero high throughout, only BEQ reacts)
        f_row(BEQ, 3'b000, 1'b0, 1'b1, 2'b10);
        d_row(BEQ, 3'b000, 1'b0, 1'b1, 2'b10);
        row(0, BEQ, 3'b000, 0, 1, 4'd10, 1, 0, 0, 0, 0, 2'b00, 3'b001, 2'b10, 2'b10, 2'b00);
        // beq not taken
        f_row(BEQ, 3'b000, 1'b0, 1'b0, 2'b10);
        d_row(BEQ, 3'b000, 1'b0, 1'b0, 2'b10);
        row(0, BEQ, 3'b000, 0, 0, 4'd10, 0, 0, 0, 0, 0, 2'b00, 3'b001, 2'b10, 2'b10, 2'b00);
        // jal: 0,1,9,7
        f_row(JAL, 3'b000, 1'b0, 1'b0, 2'b11);
        d_row(JAL, 3'b000, 1'b0, 1'b0, 2'b11);
        row(0, JAL, 3'b000, 0, 0, 4'd9, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b11, 2'b01, 2'b10);
        row(0, JAL, 3'b000, 0, 0, 4'd7, 0, 0, 1, 0, 0, 2'b00, 3'b000, 2'b11, 2'b00, 2'b00);
        // unsupported opcode: 0,1 then straight back to FETCH
        f_row(7'b0000000, 3'b000, 1'b0, 1'b0, 2'b00);
        d_row(7'b0000000, 3'b000, 1'b0, 1'b1, 2'b00);
        f_row(LW, 3'b000, 1'b0, 1'b0, 2'b00);
        rst_row(LW, 4'd1);
        apply_vecs("table");

        // Reset arriving in the write cycle must suppress the write and restart at FETCH
        f_row(LW, 3'b010, 1'b0, 1'b0, 2'b00);
        d_row(LW, 3'b010, 1'b0, 1'b0, 2'b00);
        row(0, LW, 3'b010, 0, 0, 4'd2, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 2'b10, 2'b01);
        row(0, LW, 3'b010, 0, 0, 4'd3, 0, 0, 0, 0, 1, 2'b00, 3'b000, 2'b00, 2'b00, 2'b00);
        rst_row(LW, 4'd4);
        f_row(SW, 3'b010, 1'b0, 1'b0, 2'b01);
        d_row(SW, 3'b010, 1'b0, 1'b0, 2'b01);
        row(0, SW, 3'b010, 0, 0, 4'd2, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b01, 2'b10, 2'b01);
        rst_row(SW, 4'd5);
        f_row(JAL, 3'b000, 1'b0, 1'b0, 2'b11);
        d_row(JAL, 3'b000, 1'b0, 1'b0, 2'b11);
        rst_row(JAL, 4'd9);
        rst_row(JAL, 4'd0);
        f_row(BEQ, 3'b000, 1'b0, 1'b1, 2'b10);
        d_row(BEQ, 3'b000, 1'b0, 1'b1, 2'b10);
        rst_row(BEQ, 4'd10);
        apply_vecs("reset_abort");

        // Reference model tables for the random run
        for (int i = 0; i < 16; i++) setc(i, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        setc(0,  1, 0, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00);
        setc(1,  0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00);
        setc(2,  0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00);
        setc(3,  0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        setc(4,  0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00);
        setc(5,  0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00);
        setc(6,  0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10);
        setc(7,  0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00);
        setc(8,  0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10);
        setc(9,  1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00);
        setc(10, 0, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01);
        pool[0] = LW; pool[1] = SW; pool[2] = RT; pool[3] = IT; pool[4] = BEQ; pool[5] = JAL;

        // Randomized run; the previous sequence ended with reset so we start in FETCH
        m_idx   = 0;
        m_state = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_idx == 0) begin
                if ($urandom_range(0, 7) < 6) bus.opcode = pool[$urandom_range(0, 5)];
                else                          bus.opcode = 7'($urandom);
                bus.funct3   = 3'($urandom);
                bus.funct7b5 = 1'($urandom);
                build_seq(bus.opcode);
            end
            reset    = ($urandom_range(0, 29) == 0);
            bus.zero = 1'($urandom);
            #4;
            check(ref_out(reset, m_state, bus.opcode, bus.funct3, bus.funct7b5, bus.zero),
                  $sformatf("random[%0d]", c));
            @(posedge clock);
            #1;
            if (reset || (m_idx + 1 >= seq.size())) m_idx = 0;
            else                                    m_idx = m_idx + 1;
            m_state = seq[m_idx];
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
